// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect, and decode handoff.
// Latency: none, wires only.
// Backpressure: imem_ready stalls requests, if_ready stalls the decode handoff; responses have none.
//
// Signals:
//   imem_req/imem_addr/imem_ready   in-order request channel toward instruction memory
//   imem_rvalid/imem_rdata          response channel, no backpressure
//   redirect_valid/redirect_pc      flush and restart request from branch resolution
//   if_valid/if_ready/if_pc/if_instr  (pc, instr) handoff toward decode
interface fetch_unit_if #(
    parameter int PC_W = 9
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [PC_W-1:0] if_pc;
    logic [31:0]     if_instr;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr,
        input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
    );

    // Environment side: memory, branch resolution and decode.
    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr,
        output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: holds the PC, issues in-order imem requests, and queues returned words for decode.
// Latency: request accepted at T, response at T+1, head valid to decode at T+2 (no bypass).
// Backpressure: requests are credit-limited so that in-flight plus queued never exceeds FQ_DEPTH; if_ready holds the head.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         fetch_unit_if master: imem request/response, redirect, decode handoff
module fetch_unit #(
    parameter int PC_W     = 9,
    parameter int RESET_PC = 0,
    parameter int FQ_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = $clog2(FQ_DEPTH + 1);

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  resp_pc;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] discard_cnt;
    logic [CNT_W-1:0] fq_cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [PC_W-1:0]  fq_pc    [FQ_DEPTH];
    logic [31:0]      fq_instr [FQ_DEPTH];

    logic             credit_ok;
    logic             accept;
    logic             push;
    logic             drop;
    logic             pop;
    logic [PC_W-1:0]  redirect_base;

    // One extra bit so the sum of two counters cannot overflow before comparing.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fq_cnt}) < (CNT_W + 1)'(FQ_DEPTH);

    // The reset term makes the request drop the moment rst_n falls, not at the next edge.
    assign bus.imem_req  = rst_n && !bus.redirect_valid && credit_ok;
    assign bus.imem_addr = fetch_pc;

    assign accept = bus.imem_req && bus.imem_ready;
    assign drop   = bus.imem_rvalid && (discard_cnt != '0);
    // A redirect flushes, so a response arriving in that cycle is never queued.
    assign push   = bus.imem_rvalid && (discard_cnt == '0) && !bus.redirect_valid;
    assign pop    = bus.if_valid && bus.if_ready && !bus.redirect_valid;

    assign redirect_base = {bus.redirect_pc[PC_W-1:2], 2'b00};

    assign bus.if_valid = (fq_cnt != '0);
    // Storage is not reset; an empty queue shows zeros instead of stale entries.
    assign bus.if_pc    = bus.if_valid ? fq_pc[rd_ptr]    : '0;
    assign bus.if_instr = bus.if_valid ? fq_instr[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= PC_W'(RESET_PC);
            resp_pc     <= PC_W'(RESET_PC);
            inflight    <= '0;
            discard_cnt <= '0;
            fq_cnt      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (bus.redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old path.
            fetch_pc    <= redirect_base;
            resp_pc     <= redirect_base;
            inflight    <= inflight - CNT_W'(bus.imem_rvalid);
            discard_cnt <= inflight - CNT_W'(bus.imem_rvalid);
            fq_cnt      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + PC_W'(4);
            end
            inflight <= inflight + CNT_W'(accept) - CNT_W'(bus.imem_rvalid);
            if (drop) begin
                discard_cnt <= discard_cnt - CNT_W'(1);
            end
            if (push) begin
                resp_pc <= resp_pc + PC_W'(4);
                wr_ptr  <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fq_cnt <= fq_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Credit accounting guarantees a free slot whenever push is high.
    always_ff @(posedge clk) begin
        if (push) begin
            fq_pc[wr_ptr]    <= resp_pc;
            fq_instr[wr_ptr] <= bus.imem_rdata;
        end
    end
endmodule
